mc_core: RTL

Parametrised multicycle MIPS-subset core: the datapath together with its own FSM controller. Memory sits outside behind a ready/valid-style request handshake, so the core tolerates variable memory latency. It is the next-generation replacement for the separate datapath-plus-external-controller pairing. The core adds bne, addi, slti and jr, an illegal-opcode trap, and a configurable reset vector and address width.

---
 rtl/mc_core.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_core.sv
// mc_core: multicycle MIPS-subset core with an integrated FSM controller.
// Memory is reached through a held rd/wr request that completes on mem_ready,
// so any number of wait cycles can be inserted by the memory system.
module mc_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [3:0]        state,
  output logic              trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25, FN_SLT  = 6'h2A, FN_JR   = 6'h08;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluOut_q, aluOut_d, mdr_q, mdr_d;
  logic        trap_q, trap_d;
  logic [31:0] regs_q [32];

  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;
  logic        memRd, memWr;
  logic [31:0] memAddrFull;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sextImm, branchTarget, jumpTarget;

  assign op           = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign sextImm      = {{16{ir_q[15]}}, ir_q[15:0]};
  // pc_q already holds PC+4 once the fetch has completed
  assign branchTarget = pc_q + {sextImm[29:0], 2'b00};
  assign jumpTarget   = {pc_q[31:28], ir_q[25:0], 2'b00};

  // Controller: next state, datapath register updates and memory requests
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    aluOut_d    = aluOut_q;
    mdr_d       = mdr_q;
    trap_d      = trap_q;
    rfWe        = 1'b0;
    rfWaddr     = 5'd0;
    rfWdata     = 32'd0;
    memRd       = 1'b0;
    memWr       = 1'b0;
    memAddrFull = pc_q;
    case (state_q)
      S_FETCH: begin
        memRd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = regs_q[rs];
        b_d      = regs_q[rt];
        aluOut_d = branchTarget;
        case (op)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                funct == FN_OR || funct == FN_SLT || funct == FN_JR) begin
              state_d = S_REXEC;
            end else begin
              state_d = S_TRAP;
              trap_d  = 1'b1;
            end
          end
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluOut_d = a_q + sextImm;
        state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRd       = 1'b1;
        memAddrFull = aluOut_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rfWe    = 1'b1;
        rfWaddr = rt;
        rfWdata = mdr_q;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        memWr       = 1'b1;
        memAddrFull = aluOut_q;
        if (mem_ready) state_d = S_FETCH;
      end
      S_REXEC: begin
        case (funct)
          FN_ADD:  aluOut_d = a_q + b_q;
          FN_SUB:  aluOut_d = a_q - b_q;
          FN_AND:  aluOut_d = a_q & b_q;
          FN_OR:   aluOut_d = a_q | b_q;
          FN_SLT:  aluOut_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: aluOut_d = aluOut_q;
        endcase
        if (funct == FN_JR) begin
          pc_d    = a_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_RWB;
        end
      end
      S_RWB: begin
        rfWe    = 1'b1;
        rfWaddr = rd;
        rfWdata = aluOut_q;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        if (op == OP_ADDI) aluOut_d = a_q + sextImm;
        else               aluOut_d = {31'd0, $signed(a_q) < $signed(sextImm)};
        state_d = S_IWB;
      end
      S_IWB: begin
        rfWe    = 1'b1;
        rfWaddr = rt;
        rfWdata = aluOut_q;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if ((a_q == b_q) ^ (op == OP_BNE)) pc_d = aluOut_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = jumpTarget;
        state_d = S_FETCH;
      end
      S_JAL: begin
        rfWe    = 1'b1;
        rfWaddr = 5'd31;
        rfWdata = pc_q;
        pc_d    = jumpTarget;
        state_d = S_FETCH;
      end
      S_TRAP: trap_d = 1'b1;
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  // Datapath and controller state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluOut_q <= 32'd0;
      mdr_q    <= 32'd0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluOut_q <= aluOut_d;
      mdr_q    <= mdr_d;
      trap_q   <= trap_d;
    end
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (rfWe && rfWaddr != 5'd0) begin
      regs_q[rfWaddr] <= rfWdata;
    end
  end

  // Requests are suppressed while reset is asserted so a pending one drops at once
  assign mem_rd    = memRd & ~rst;
  assign mem_wr    = memWr & ~rst;
  assign mem_addr  = memAddrFull[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign trap      = trap_q;

endmodule
